// File: rtl/led_stepper_pkg.sv
// Shared definitions for the LED stepper.
//   mode_t        : 2-bit display mode (DOT, BAR, OFF; encoding 3 unused)
//   mode_advance  : next mode on a mode-button press
package led_stepper_pkg;

   typedef enum logic [1:0] {
      MODE_DOT = 2'd0,
      MODE_BAR = 2'd1,
      MODE_OFF = 2'd2
   } mode_t;

   // DOT -> BAR -> OFF -> DOT; the unused encoding falls back to DOT.
   function automatic mode_t mode_advance(input mode_t m);
      case (m)
         MODE_DOT: mode_advance = MODE_BAR;
         MODE_BAR: mode_advance = MODE_OFF;
         default:  mode_advance = MODE_DOT;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer with press-pulse output.
//   clk, rst : clock and synchronous active-high reset
//   btn_raw  : raw asynchronous button pin
//   press    : registered one-cycle pulse on a debounced 0->1 transition
//   level    : debounced pressed state (1 = pressed)
module btn_debounce
   import led_stepper_pkg::*;
#(
   parameter int DEB_BITS   = 16,
   parameter int ACTIVE_LOW = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press,
   output logic level
);

   logic                btn_in;
   logic                sync1_reg;
   logic                sync2_reg;
   logic                state_reg;
   logic                press_reg;
   logic                hold_reg;
   logic [1:0]          fill_reg;
   logic [DEB_BITS-1:0] cnt_reg;

   assign btn_in = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

   // hold_reg suppresses the press pulse for a button that was already down
   // when reset ended. It clears once a released level has come through the
   // synchroniser; fill_reg marks when sync2_reg holds a real sample again.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         state_reg <= 1'b0;
         press_reg <= 1'b0;
         hold_reg  <= 1'b1;
         fill_reg  <= 2'b00;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= btn_in;
         sync2_reg <= sync1_reg;
         fill_reg  <= {fill_reg[0], 1'b1};
         press_reg <= 1'b0;
         if (sync2_reg != state_reg) begin
            if (&cnt_reg) begin
               state_reg <= sync2_reg;
               cnt_reg   <= '0;
               if (sync2_reg && !hold_reg)
                  press_reg <= 1'b1;
            end else begin
               cnt_reg <= cnt_reg + DEB_BITS'(1);
            end
         end else begin
            cnt_reg <= '0;
         end
         if (fill_reg[1] && !sync2_reg)
            hold_reg <= 1'b0;
      end
   end

   assign press = press_reg;
   assign level = state_reg;

endmodule

// File: rtl/led_stepper.sv
// Button-driven LED position stepper.
//   clk, rst            : clock and synchronous active-high reset
//   btn_up/down/mode    : raw buttons (step up, step down, next display mode)
//   led  [NUM_LEDS]     : registered LED drive, active-high
//   pos  [clog2(NUM)]   : registered current position
//   mode [2]            : registered display mode
module led_stepper
   import led_stepper_pkg::*;
#(
   parameter int NUM_LEDS       = 4,
   parameter int DEB_BITS       = 16,
   parameter int WRAP           = 1,
   parameter int BTN_ACTIVE_LOW = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        btn_up,
   input  logic                        btn_down,
   input  logic                        btn_mode,
   output logic [NUM_LEDS-1:0]         led,
   output logic [$clog2(NUM_LEDS)-1:0] pos,
   output mode_t                       mode
);

   localparam int PW = $clog2(NUM_LEDS);
   localparam logic [PW-1:0] LAST = PW'(NUM_LEDS - 1);

   logic                up_p, down_p, mode_p;
   logic [2:0]          level_unused;
   logic [PW-1:0]       pos_reg, pos_next;
   mode_t               mode_reg, mode_next;
   logic [NUM_LEDS-1:0] led_reg, led_next;

   btn_debounce #(.DEB_BITS(DEB_BITS), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_up (
      .clk(clk), .rst(rst), .btn_raw(btn_up),   .press(up_p),   .level(level_unused[0]));
   btn_debounce #(.DEB_BITS(DEB_BITS), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_down (
      .clk(clk), .rst(rst), .btn_raw(btn_down), .press(down_p), .level(level_unused[1]));
   btn_debounce #(.DEB_BITS(DEB_BITS), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_mode (
      .clk(clk), .rst(rst), .btn_raw(btn_mode), .press(mode_p), .level(level_unused[2]));

   // Stepping uses the current mode, so a simultaneous mode press does not
   // block a step taken while leaving DOT/BAR.
   always_comb begin
      pos_next = pos_reg;
      if (mode_reg != MODE_OFF) begin
         if (up_p && !down_p) begin
            if (pos_reg == LAST)
               pos_next = (WRAP != 0) ? '0 : LAST;
            else
               pos_next = pos_reg + PW'(1);
         end else if (down_p && !up_p) begin
            if (pos_reg == '0)
               pos_next = (WRAP != 0) ? LAST : '0;
            else
               pos_next = pos_reg - PW'(1);
         end
      end
   end

   always_comb begin
      mode_next = mode_reg;
      if (mode_p || (mode_reg != MODE_DOT && mode_reg != MODE_BAR && mode_reg != MODE_OFF))
         mode_next = mode_advance(mode_reg);
   end

   // LED pattern is decoded from the next state so all three outputs
   // change together on the same edge.
   generate
      for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
         assign led_next[gi] = ((mode_next == MODE_DOT) && (PW'(gi) == pos_next)) ||
                               ((mode_next == MODE_BAR) && (PW'(gi) <= pos_next));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_reg  <= '0;
         mode_reg <= MODE_DOT;
         led_reg  <= NUM_LEDS'(1);
      end else begin
         pos_reg  <= pos_next;
         mode_reg <= mode_next;
         led_reg  <= led_next;
      end
   end

   assign led  = led_reg;
   assign pos  = pos_reg;
   assign mode = mode_reg;

endmodule
